// File: rtl/lut_cluster_pkg.sv
// Shared types and sizing helpers for the LUT cluster and its cells.
package lut_cluster_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } load_state_e;

   // Each LUT owns a 2^K-entry truth table plus one mode bit.
   function automatic int cfg_bits_f(input int inputs, input int luts);
      return luts * ((1 << inputs) + 1);
   endfunction

   function automatic int cfg_bytes_f(input int inputs, input int luts);
      return (cfg_bits_f(inputs, luts) + 7) / 8;
   endfunction

   // Byte counter width; a single-byte load still needs a 1-bit counter.
   function automatic int cnt_width_f(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/lut_cell.sv
// One K-input LUT: truth-table lookup, optional output register, mode mux.
module lut_cell
   import lut_cluster_pkg::*;
#(
   parameter int INPUTS = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [INPUTS-1:0]        addr,
   input  logic [(1<<INPUTS)-1:0]   truth_tbl,
   input  logic                     mode,
   input  logic                     en,
   input  logic                     configured,
   output logic                     out_bit
);

   logic lut_val;
   logic q_q;
   logic q_d;

   // Table lookup and register next-value; q holds unless enabled and configured.
   always_comb begin
      lut_val = truth_tbl[addr];
      q_d     = q_q;
      if (en && configured) begin
         q_d = lut_val;
      end
   end

   // Output register for registered-mode operation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   // Output mux; nothing escapes until a configuration has committed.
   always_comb begin
      out_bit = 1'b0;
      if (configured) begin
         out_bit = mode ? q_q : lut_val;
      end
   end

endmodule

// File: rtl/lut_cluster.sv
// LUT cluster: byte-serial configuration loader with shadow/active config
// double-buffering, driving LUTS instances of lut_cell.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no load in progress; cfg_valid ignored
// ST_LOAD | accepting config bytes into shadow; active config untouched
module lut_cluster
   import lut_cluster_pkg::*;
#(
   parameter int INPUTS = 4,
   parameter int LUTS   = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [LUTS*INPUTS-1:0]   in,
   input  logic                     en,
   input  logic                     cfg_start,
   input  logic                     cfg_valid,
   input  logic [7:0]               cfg_data,
   output logic                     cfg_ready,
   output logic                     cfg_done,
   output logic                     configured,
   output logic [LUTS-1:0]          out
);

   localparam int TBL       = 1 << INPUTS;
   localparam int CELL      = TBL + 1;
   localparam int CFG_BITS  = cfg_bits_f(INPUTS, LUTS);
   localparam int CFG_BYTES = cfg_bytes_f(INPUTS, LUTS);
   localparam int CNT_W     = cnt_width_f(CFG_BYTES);

   load_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CFG_BITS-1:0]  shadow_q, shadow_d;
   logic [CFG_BITS-1:0]  active_q, active_d;
   logic                 configured_q, configured_d;
   logic                 done_q, done_d;
   logic                 last_byte;

   assign last_byte = (cnt_q == CNT_W'(CFG_BYTES - 1));

   // Loader next-state: start always wins over data; the final byte commits
   // the shadow (including that byte) into the active config in one edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      configured_d = configured_q;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               cnt_d = '0;
            end else if (cfg_valid) begin
               // Bits past CFG_BITS in the final byte have no home and drop.
               for (int k = 0; k < CFG_BITS; k++) begin
                  if (cnt_q == CNT_W'(k / 8)) begin
                     shadow_d[k] = cfg_data[k % 8];
                  end
               end
               if (last_byte) begin
                  active_d     = shadow_d;
                  configured_d = 1'b1;
                  done_d       = 1'b1;
                  state_d      = ST_IDLE;
                  cnt_d        = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Loader and configuration registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         configured_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         configured_q <= configured_d;
         done_q       <= done_d;
      end
   end

   assign cfg_ready  = (state_q == ST_LOAD);
   assign cfg_done   = done_q;
   assign configured = configured_q;

   for (genvar i = 0; i < LUTS; i++) begin : g_cell
      lut_cell #(
         .INPUTS (INPUTS)
      ) u_cell (
         .clock      (clock),
         .reset      (reset),
         .addr       (in[i*INPUTS +: INPUTS]),
         .truth_tbl  (active_q[i*CELL +: TBL]),
         .mode       (active_q[i*CELL + TBL]),
         .en         (en),
         .configured (configured_q),
         .out_bit    (out[i])
      );
   end

endmodule

// File: tb/tb_lut_cluster.sv
// Directed bench for lut_cluster at INPUTS=2, LUTS=2 (10 config bits, 2 bytes).
module tb_lut_cluster;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] in_v;
   logic       en;
   logic       cfg_start;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       cfg_ready;
   logic       cfg_done;
   logic       configured;
   logic [1:0] out_v;

   int checks   = 0;
   int failures = 0;

   lut_cluster #(
      .INPUTS (2),
      .LUTS   (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in         (in_v),
      .en         (en),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .configured (configured),
      .out        (out_v)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] in;
      logic       en;
      logic [1:0] exp_out;
   } vec_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Two-byte load with checks on ready/done timing and on out staying at
   // exp_during while the old configuration is still active.
   task automatic load2(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [1:0] exp_during);
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      chk("ready_after_start", {7'd0, cfg_ready}, 8'd1);
      cfg_valid = 1'b1;
      cfg_data  = b0;
      #1;
      chk("out_before_b0", {6'd0, out_v}, {6'd0, exp_during});
      cyc();
      chk("done_after_b0", {7'd0, cfg_done}, 8'd0);
      chk("ready_after_b0", {7'd0, cfg_ready}, 8'd1);
      chk("out_after_b0", {6'd0, out_v}, {6'd0, exp_during});
      cfg_data = b1;
      cyc();
      cfg_valid = 1'b0;
      chk("done_after_last", {7'd0, cfg_done}, 8'd1);
      chk("configured_after_last", {7'd0, configured}, 8'd1);
      chk("ready_after_last", {7'd0, cfg_ready}, 8'd0);
   endtask

   vec_t vecs[10];

   initial begin
      logic prev_q1;

      // LUT0 = AND (comb) on in[1:0], LUT1 = XOR (registered) on in[3:2]
      vecs[0] = '{4'b1011, 1'b1, 2'b11};
      vecs[1] = '{4'b0011, 1'b1, 2'b01};
      vecs[2] = '{4'b1100, 1'b1, 2'b00};
      vecs[3] = '{4'b0110, 1'b1, 2'b10};
      vecs[4] = '{4'b1000, 1'b0, 2'b10};
      vecs[5] = '{4'b0011, 1'b0, 2'b11};
      vecs[6] = '{4'b1111, 1'b0, 2'b11};
      vecs[7] = '{4'b1111, 1'b1, 2'b01};
      vecs[8] = '{4'b0101, 1'b1, 2'b10};
      vecs[9] = '{4'b1001, 1'b0, 2'b10};

      reset     = 1'b1;
      in_v      = 4'b1111;
      en        = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      cyc();
      cyc();
      chk("in_reset", {out_v, configured, cfg_ready, cfg_done}, 8'd0);
      reset = 1'b0;

      // Unconfigured: out stays zero regardless of inputs.
      for (int c = 0; c < 10; c++) begin
         cyc();
         chk("unconfigured_idle", {out_v, configured, cfg_ready, cfg_done}, 8'd0);
      end

      // First load: AND comb / XOR registered.
      in_v = 4'b1011;
      load2(8'hC8, 8'h02, 2'b00);
      chk("first_commit_out", {6'd0, out_v}, 8'h01);
      cyc();
      chk("done_one_cycle", {7'd0, cfg_done}, 8'd0);
      chk("reg_lut_latency", {6'd0, out_v}, 8'h03);
      prev_q1 = 1'b1;

      for (int i = 0; i < 10; i++) begin
         in_v = vecs[i].in;
         en   = vecs[i].en;
         #1;
         chk($sformatf("vec%0d_pre", i), {6'd0, out_v}, {6'd0, prev_q1, vecs[i].exp_out[0]});
         cyc();
         chk($sformatf("vec%0d_post", i), {6'd0, out_v}, {6'd0, vecs[i].exp_out});
         prev_q1 = vecs[i].exp_out[1];
      end

      // Live reload: LUT0 table 0111 comb, LUT1 table 0000 comb.
      en   = 1'b1;
      in_v = 4'b0001;
      cyc();
      chk("reload_pre", {6'd0, out_v}, 8'h00);
      load2(8'h07, 8'h00, 2'b00);
      chk("reload_commit_out", {6'd0, out_v}, 8'h01);
      cyc();
      chk("reload_ready_idle", {7'd0, cfg_ready}, 8'd0);

      // Restart mid-load: start with valid set must not accept the byte.
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = 8'hC8;
      cyc();
      cfg_start = 1'b1;
      cfg_data  = 8'h02;
      cyc();
      cfg_start = 1'b0;
      chk("restart_ready", {7'd0, cfg_ready}, 8'd1);
      chk("restart_no_done", {7'd0, cfg_done}, 8'd0);
      chk("restart_old_cfg", {6'd0, out_v}, 8'h01);
      cfg_data = 8'hC8;
      cyc();
      chk("restart_b0_no_done", {7'd0, cfg_done}, 8'd0);
      chk("restart_b0_old_cfg", {6'd0, out_v}, 8'h01);
      cfg_data = 8'h02;
      cyc();
      cfg_valid = 1'b0;
      chk("restart_done", {7'd0, cfg_done}, 8'd1);
      in_v = 4'b1011;
      #1;
      chk("restart_new_cfg", {6'd0, out_v[0]}, 8'h01);
      cyc();
      chk("restart_new_reg", {6'd0, out_v}, 8'h03);

      // Reset in the middle of a load.
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = 8'h07;
      cyc();
      reset = 1'b1;
      #1;
      chk("midload_reset", {out_v, configured, cfg_ready, cfg_done}, 8'd0);
      cyc();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cfg_data = (c == 0) ? 8'hC8 : ((c == 1) ? 8'h02 : 8'hFF);
         cyc();
         chk("valid_without_start", {out_v, configured, cfg_ready, cfg_done}, 8'd0);
      end
      cfg_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lut_cluster.md
LUT_CLUSTER -- requirements
Module: lut_cluster

Interface
REQ-001 SHALL have parameter INPUTS, default 4: inputs per LUT (K), legal 1..6.
REQ-002 SHALL have parameter LUTS, default 4: LUT count (N), legal 1..16.
REQ-003 SHALL derive CFG_BITS = LUTS*(2^INPUTS+1) and CFG_BYTES = ceil(CFG_BITS/8).
REQ-004 clock  in  1  sole clock, rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in  in  LUTS*INPUTS  LUT i address = in[i*INPUTS +: INPUTS].
REQ-007 en  in  1  enable for registered LUT outputs.
REQ-008 cfg_start  in  1  one-cycle pulse; begins or restarts a configuration load.
REQ-009 cfg_valid  in  1  cfg_data valid.
REQ-010 cfg_data  in  8  configuration byte.
REQ-011 cfg_ready  out  1  high while in LOAD.
REQ-012 cfg_done  out  1  one-cycle pulse after a complete load commits.
REQ-013 configured  out  1  high once any complete configuration has committed.
REQ-014 out  out  LUTS  LUT outputs.

Function
REQ-015 Config vector SHALL be CFG_BITS wide; LUT i owns bits [i*(2^K+1) +: 2^K+1]: low 2^K bits = truth table indexed by address, top bit = mode (1 = registered, 0 = combinational).
REQ-016 States: IDLE, LOAD; IDLE -> LOAD on cfg_start; LOAD -> IDLE on acceptance of byte CFG_BYTES-1.
REQ-017 Byte accepted on a rising edge with cfg_valid && cfg_ready; byte j SHALL fill shadow bits [8j +: 8], LSB first; bits beyond CFG_BITS discarded.
REQ-018 cfg_start in LOAD SHALL zero the byte counter and stay in LOAD; any cfg_valid in that cycle SHALL NOT be accepted (start wins).
REQ-019 cfg_valid in IDLE SHALL be ignored.
REQ-020 Acceptance of the last byte SHALL copy shadow (including that byte) to active config atomically on that edge, set configured, and assert cfg_done for exactly the following cycle.
REQ-021 Active config SHALL stay unchanged during LOAD; LUTs keep operating on the old config (live reload).
REQ-022 Combinational LUT: out[i] = table_i[addr_i] from active config, zero latency.
REQ-023 Registered LUT: q[i] <= table_i[addr_i] on each edge with en && configured; out[i] = q[i]; latency 1 cycle; q holds when en = 0.
REQ-024 At commit, q SHALL keep its value; the next enabled edge uses the new table.
REQ-025 While configured = 0, out SHALL be all-zero regardless of in.

Reset
REQ-026 Reset SHALL force state IDLE, byte counter 0, shadow and active config 0, q 0, configured 0, cfg_done 0, cfg_ready 0, out 0.
REQ-027 Reset during LOAD SHALL discard the partial load; a new cfg_start is required.

Structure
REQ-028 Package lut_cluster_pkg SHALL hold the state enum and CFG_BITS/CFG_BYTES width functions.
REQ-029 Sub-module lut_cell (one K-input table, mode mux, output flop, en) SHALL be instantiated LUTS times; loader FSM, counter and config registers in lut_cluster.

Verification (INPUTS=2, LUTS=2: CFG_BITS=10, CFG_BYTES=2)
REQ-030 Reset, in=4'b1111, en=1 -> out=2'b00, configured=0, cfg_ready=0 for 10 cycles.
REQ-031 cfg_start, bytes 0xC8 then 0x02 (LUT0 AND comb, LUT1 XOR registered) -> cfg_done pulses once the cycle after byte 2; configured=1; in=4'b1011 -> out[0]=1 same cycle, out[1]=1 one edge later.
REQ-032 Configured as REQ-031, en=0, toggle in[3:2] -> out[1] frozen; en=1 -> tracks with 1-cycle latency.
REQ-033 Reload with 0x07,0x00 (LUT0 table 0111 comb, LUT1 table 0000 comb); in=4'b0001 -> out[0]=0 until commit, then 1; cfg_ready=1 only between start and last byte.
REQ-034 cfg_start asserted with cfg_valid mid-load after byte 0 -> counter restarts, old config still active, two further bytes required for cfg_done.
REQ-035 Reset asserted mid-load after one byte -> all outputs 0, configured=0; cfg_valid without cfg_start accepted nowhere.
